// File: rtl/alu_seq_ctrl.sv
// Request/response sequencer for an external multi-cycle ALU: registers operands,
// waits SETTLE cycles, captures result and flags, and counts completed responses.
module alu_seq_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_s,
  input  logic        alu_eq,
  input  logic        alu_cary,
  input  logic        alu_of,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_s,
  output logic        rsp_eq,
  output logic        rsp_c,
  output logic        rsp_v,
  output logic        rsp_err,
  output logic [15:0] ops_done
);
  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_NOR    = 3'b101;
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [2:0]  r_alu_op;
  logic [31:0] r_rsp_s;
  logic        r_rsp_eq;
  logic        r_rsp_c;
  logic        r_rsp_v;
  logic        r_rsp_err;
  logic [15:0] r_ops_done;

  logic w_legal;
  logic w_req_hs;
  logic w_capture;
  logic w_rsp_hs;
  logic w_arith;

  assign w_legal   = (req_op <= OP_NOR);
  assign w_req_hs  = req_valid && (r_state == IDLE);
  assign w_capture = (r_state == WAIT) && (r_cnt == 4'd1);
  assign w_rsp_hs  = (r_state == RESP) && rsp_ready;
  // Carry/overflow only mean something for arithmetic; logic ops leave them floating.
  assign w_arith   = (r_alu_op == OP_ADD) || (r_alu_op == OP_SUB);

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    unique case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = w_legal ? WAIT : RESP;
      end
      WAIT: begin
        if (r_cnt == 4'd1) w_state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_req_hs && w_legal) r_cnt <= SETTLE_LD;
      else if (r_state == WAIT) r_cnt <= r_cnt - 4'd1;
    end
  end

  // Operands are held from acceptance through capture; illegal ops leave them untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a  <= 32'd0;
      r_alu_b  <= 32'd0;
      r_alu_op <= 3'b000;
    end else if (w_req_hs && w_legal) begin
      r_alu_a  <= req_a;
      r_alu_b  <= req_b;
      r_alu_op <= req_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_s   <= 32'd0;
      r_rsp_eq  <= 1'b0;
      r_rsp_c   <= 1'b0;
      r_rsp_v   <= 1'b0;
      r_rsp_err <= 1'b0;
    end else if (w_req_hs && !w_legal) begin
      r_rsp_s   <= 32'd0;
      r_rsp_eq  <= 1'b0;
      r_rsp_c   <= 1'b0;
      r_rsp_v   <= 1'b0;
      r_rsp_err <= 1'b1;
    end else if (w_capture) begin
      r_rsp_s   <= alu_s;
      r_rsp_eq  <= alu_eq;
      r_rsp_c   <= w_arith ? alu_cary : 1'b0;
      r_rsp_v   <= w_arith ? alu_of : 1'b0;
      r_rsp_err <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ops_done <= 16'd0;
    else if (w_rsp_hs) r_ops_done <= r_ops_done + 16'd1;
  end

  assign alu_a    = r_alu_a;
  assign alu_b    = r_alu_b;
  assign alu_op   = r_alu_op;
  assign rsp_s    = r_rsp_s;
  assign rsp_eq   = r_rsp_eq;
  assign rsp_c    = r_rsp_c;
  assign rsp_v    = r_rsp_v;
  assign rsp_err  = r_rsp_err;
  assign ops_done = r_ops_done;
endmodule
